hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RISC-V core. It drives the enable (`en`) and synchronous flush (`r`) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable. It resolves four cases: load-use hazards, taken branches/jumps, multi-cycle EX operations (mul/div) and data-memory wait states. It also keeps two saturating performance counters.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/sat_counter.sv | 29 ++
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam int CNT_W_DEFAULT = 16;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MC_BUSY    = 2'd1,
    MC_HOLD    = 2'd2,
    MC_RELEASE = 2'd3
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Unsigned event counter that sticks at all-ones instead of wrapping.
// One-cycle update latency; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         r,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != MAX)) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) cnt_q <= '0;
    else   cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline enable/flush controller: load-use, branch, multi-cycle EX and dmem waits.
// Controls are combinational (same-edge effect); FSM and counters are registered.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             r,
  input  logic             MemRead_ex,
  input  logic [4:0]       rdAddr_ex,
  input  logic [4:0]       rs1Addr_id,
  input  logic [4:0]       rs2Addr_id,
  input  logic             rs1Used_id,
  input  logic             rs2Used_id,
  input  logic             BranchTaken_ex,
  input  logic             McOp_ex,
  input  logic             mc_done,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IDEX_en,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic             IFID_r,
  output logic             IDEX_r,
  output logic             EXMEM_r,
  output logic             mc_go,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t state_q, state_d;

  logic memstall, loaduse;
  logic run_rules, mc_allow, mc_stall;
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_r_c, idex_r_c, exmem_r_c, mc_go_c, flush_evt;

  assign memstall = dmem_req_mem & ~dmem_ready;
  assign loaduse  = MemRead_ex & (rdAddr_ex != REG_X0) &
                    ((rs1Used_id & (rdAddr_ex == rs1Addr_id)) |
                     (rs2Used_id & (rdAddr_ex == rs2Addr_id)));

  always_comb begin
    state_d    = state_q;
    pc_en_c    = 1'b1;
    ifid_en_c  = 1'b1;
    idex_en_c  = 1'b1;
    exmem_en_c = 1'b1;
    memwb_en_c = 1'b1;
    ifid_r_c   = 1'b0;
    idex_r_c   = 1'b0;
    exmem_r_c  = 1'b0;
    mc_go_c    = 1'b0;
    flush_evt  = 1'b0;
    run_rules  = 1'b0;
    mc_allow   = 1'b0;
    mc_stall   = 1'b0;

    if (memstall) begin
      // Whole pipe frozen; a result finishing now must be parked until release.
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      memwb_en_c = 1'b0;
      if ((state_q == MC_BUSY) && mc_done) state_d = MC_HOLD;
    end else begin
      case (state_q)
        RUN: begin
          run_rules = 1'b1;
          mc_allow  = 1'b1;
        end
        MC_BUSY: begin
          if (mc_done) begin
            run_rules = 1'b1;
            state_d   = RUN;
          end else begin
            mc_stall = 1'b1;
          end
        end
        MC_HOLD: begin
          mc_stall = 1'b1;
          state_d  = MC_RELEASE;
        end
        MC_RELEASE: begin
          run_rules = 1'b1;
          state_d   = RUN;
        end
        default: state_d = RUN;
      endcase

      if (run_rules) begin
        if (BranchTaken_ex) begin
          ifid_r_c  = 1'b1;
          idex_r_c  = 1'b1;
          flush_evt = 1'b1;
        end else if (mc_allow && McOp_ex) begin
          mc_go_c  = 1'b1;
          mc_stall = 1'b1;
          state_d  = MC_BUSY;
        end else if (loaduse) begin
          pc_en_c   = 1'b0;
          ifid_en_c = 1'b0;
          idex_r_c  = 1'b1;
        end
      end

      if (mc_stall) begin
        pc_en_c   = 1'b0;
        ifid_en_c = 1'b0;
        idex_en_c = 1'b0;
        exmem_r_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) state_q <= RUN;
    else   state_q <= state_d;
  end

  // While reset is held every register is frozen and flushed.
  assign PC_en    = ~r & pc_en_c;
  assign IFID_en  = ~r & ifid_en_c;
  assign IDEX_en  = ~r & idex_en_c;
  assign EXMEM_en = ~r & exmem_en_c;
  assign MEMWB_en = ~r & memwb_en_c;
  assign IFID_r   = r | ifid_r_c;
  assign IDEX_r   = r | idex_r_c;
  assign EXMEM_r  = r | exmem_r_c;
  assign mc_go    = ~r & mc_go_c;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .r   (r),
    .inc (~PC_en & ~r),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .r   (r),
    .inc (flush_evt & ~r),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change 1 ns after a rising edge, outputs checked on the falling edge.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic        clk = 1'b0;
  logic        r;
  logic        MemRead_ex, rs1Used_id, rs2Used_id, BranchTaken_ex, McOp_ex, mc_done;
  logic        dmem_req_mem, dmem_ready;
  logic [4:0]  rdAddr_ex, rs1Addr_id, rs2Addr_id;
  logic        PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
  logic        IFID_r, IDEX_r, EXMEM_r, mc_go;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .r(r),
    .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
    .BranchTaken_ex(BranchTaken_ex), .McOp_ex(McOp_ex), .mc_done(mc_done),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en),
    .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en),
    .IFID_r(IFID_r), .IDEX_r(IDEX_r), .EXMEM_r(EXMEM_r),
    .mc_go(mc_go), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  wire [4:0] en_v = {PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en};
  wire [2:0] fl_v = {IFID_r, IDEX_r, EXMEM_r};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemRead_ex = 0; rdAddr_ex = 0; rs1Addr_id = 0; rs2Addr_id = 0;
    rs1Used_id = 0; rs2Used_id = 0; BranchTaken_ex = 0; McOp_ex = 0;
    mc_done = 0; dmem_req_mem = 0; dmem_ready = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (en_v !== 5'b00000) begin errors++; $display("FAIL reset_en: got %b want 00000", en_v); end
    checks++; if (fl_v !== 3'b111) begin errors++; $display("FAIL reset_flush: got %b want 111", fl_v); end
    checks++; if (mc_go !== 1'b0) begin errors++; $display("FAIL reset_mc_go: got %b want 0", mc_go); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    step(); r = 0;
    @(negedge clk);
    checks++; if (en_v !== 5'b11111 || fl_v !== 3'b000) begin errors++; $display("FAIL post_reset_idle: got en %b fl %b want 11111/000", en_v, fl_v); end
  endtask

  task automatic test_loaduse();
    step(); idle();
    MemRead_ex = 1; rdAddr_ex = 5; rs1Addr_id = 3; rs1Used_id = 1; rs2Addr_id = 5; rs2Used_id = 1;
    @(negedge clk);
    checks++; if (en_v !== 5'b00111 || fl_v !== 3'b010) begin errors++; $display("FAIL loaduse_ctrl: got en %b fl %b want 00111/010", en_v, fl_v); end
    step(); idle();
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd1 || PC_en !== 1'b1) begin errors++; $display("FAIL loaduse_cnt: got %0d pc_en %b want 1/1", stall_cnt, PC_en); end
  endtask

  task automatic test_no_hazard();
    step(); idle();
    MemRead_ex = 1; rdAddr_ex = 0; rs1Addr_id = 0; rs1Used_id = 1;
    @(negedge clk);
    checks++; if (en_v !== 5'b11111 || fl_v !== 3'b000) begin errors++; $display("FAIL load_x0: got en %b fl %b want 11111/000", en_v, fl_v); end
    step(); idle();
    MemRead_ex = 1; rdAddr_ex = 7; rs1Addr_id = 7; rs1Used_id = 0; rs2Addr_id = 8; rs2Used_id = 1;
    @(negedge clk);
    checks++; if (en_v !== 5'b11111 || fl_v !== 3'b000) begin errors++; $display("FAIL rs1_unused: got en %b fl %b want 11111/000", en_v, fl_v); end
    step(); idle();
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL no_hazard_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_branch_over_loaduse();
    step(); idle();
    BranchTaken_ex = 1; MemRead_ex = 1; rdAddr_ex = 9; rs1Addr_id = 9; rs1Used_id = 1;
    @(negedge clk);
    checks++; if (en_v !== 5'b11111 || fl_v !== 3'b110) begin errors++; $display("FAIL branch_ctrl: got en %b fl %b want 11111/110", en_v, fl_v); end
    step(); idle();
    @(negedge clk);
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin errors++; $display("FAIL branch_cnt: got flush %0d stall %0d want 1/1", flush_cnt, stall_cnt); end
  endtask

  // The mc unit registers mc_go, then takes 4 cycles, so mc_done lands 5 cycles after the pulse.
  task automatic test_multicycle();
    int gos = 0;
    int bad = 0;
    for (int c = 0; c <= 5; c++) begin
      step(); idle();
      McOp_ex = 1; mc_done = (c == 5);
      @(negedge clk);
      if (mc_go) gos++;
      if (c < 5 && (en_v !== 5'b00011 || EXMEM_r !== 1'b1)) bad++;
      if (c == 5 && (en_v !== 5'b11111 || fl_v !== 3'b000)) bad++;
    end
    checks++; if (gos !== 1) begin errors++; $display("FAIL mc_go_pulses: got %0d want 1", gos); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mc_busy_ctrl: got %0d bad cycles want 0", bad); end
    step(); idle();
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL mc_stall_cnt: got %0d want 6", stall_cnt); end
    checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL mc_back_to_run: got %0d want %0d", dut.state_q, RUN); end
  endtask

  task automatic test_mc_memstall();
    int bad = 0;
    step(); idle(); McOp_ex = 1;
    @(negedge clk);
    checks++; if (mc_go !== 1'b1) begin errors++; $display("FAIL hold_go: got %b want 1", mc_go); end
    step(); idle(); McOp_ex = 1;
    for (int c = 0; c < 3; c++) begin
      step(); idle();
      McOp_ex = 1; dmem_req_mem = 1; dmem_ready = 0; mc_done = (c == 0);
      @(negedge clk);
      if (en_v !== 5'b00000 || fl_v !== 3'b000 || mc_go !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_freeze: got %0d bad cycles want 0", bad); end
    checks++; if (dut.state_q !== MC_HOLD) begin errors++; $display("FAIL hold_state: got %0d want %0d", dut.state_q, MC_HOLD); end
    step(); idle(); McOp_ex = 1; dmem_req_mem = 1; dmem_ready = 1;
    @(negedge clk);
    checks++; if (en_v !== 5'b00011 || fl_v !== 3'b001) begin errors++; $display("FAIL hold_drain: got en %b fl %b want 00011/001", en_v, fl_v); end
    step(); idle(); McOp_ex = 1;
    @(negedge clk);
    checks++; if (dut.state_q !== MC_RELEASE) begin errors++; $display("FAIL release_state: got %0d want %0d", dut.state_q, MC_RELEASE); end
    checks++; if (mc_go !== 1'b0 || en_v !== 5'b11111) begin errors++; $display("FAIL release_ctrl: got go %b en %b want 0/11111", mc_go, en_v); end
    step(); idle();
    @(negedge clk);
    checks++; if (dut.state_q !== RUN || stall_cnt !== 16'd12) begin errors++; $display("FAIL release_done: got state %0d stall %0d want %0d/12", dut.state_q, stall_cnt, RUN); end
  endtask

  task automatic test_reset_mid_op();
    step(); idle(); McOp_ex = 1;
    step();
    #2 r = 1;
    #1;
    checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL mid_reset_state: got %0d want %0d", dut.state_q, RUN); end
    checks++; if (en_v !== 5'b00000 || fl_v !== 3'b111 || mc_go !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got en %b fl %b go %b want 00000/111/0", en_v, fl_v, mc_go); end
    step(); r = 0; idle();
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_saturate();
    step(); idle(); dmem_req_mem = 1; dmem_ready = 0;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_saturate: got %h want ffff", stall_cnt); end
    step(); idle();
    @(negedge clk);
    checks++; if (stall_cnt !== 16'hFFFF || flush_cnt !== 16'd0) begin errors++; $display("FAIL saturate_hold: got %h/%h want ffff/0000", stall_cnt, flush_cnt); end
  endtask

  initial begin
    r = 1;
    idle();
    test_reset();
    test_loaduse();
    test_no_hazard();
    test_branch_over_loaduse();
    test_multicycle();
    test_mc_memstall();
    test_reset_mid_op();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
